addr_seq_gen: RTL
=================

# addr_seq_gen

Parametrised read-address sequencer for the systolic array's weight and data SRAM banks. On a start pulse it runs an internal serial counter and issues, every cycle, one skewed read address per bank for both the weight and data streams. Bank k lags bank 0 by k*PACK_PER_WORD serial steps so operands enter the array diagonally. Addresses that fall outside the valid window are driven to a guard address, and the bank's enable is cleared.

## Interface
- NUM_BANKS, 2: number of skewed banks per stream (weight and data each)
- ADDR_W, 10: SRAM address width
- DEPTH, 128: SRAM depth; guard address is DEPTH-1
- PACK_PER_WORD, 1: elements per 32-bit word; per-bank skew step
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- seq_len  in  ADDR_W  words per bank for this run; sampled on accepted start
- base_w  in  ADDR_W  weight-stream base address; sampled on accepted start
- base_d  in  ADDR_W  data-stream base address; sampled on accepted start
- hold  in  1  stall; freezes the sequence while high in RUN
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run
- out_valid  out  1  address outputs this cycle are a new step
- bank_en  out  NUM_BANKS  per-bank read enable, shared by both streams
- raddr_w  out  NUM_BANKS*ADDR_W  weight addresses; bank k in bits [k*ADDR_W +: ADDR_W]
- raddr_d  out  NUM_BANKS*ADDR_W  data addresses; same packing as raddr_w

## Operation
- FSM states IDLE and RUN.
  - IDLE -> RUN: on start=1 with seq_len!=0. Latch seq_len, base_w and base_d. Set cnt=0.
  - start with seq_len==0 in IDLE: no RUN. done pulses the next cycle. No out_valid.
  - start in RUN is ignored.
- TOTAL = seq_len + (NUM_BANKS-1)*PACK_PER_WORD serial steps per run.
- Each non-hold RUN cycle:
  - Output registers load f(cnt); out_valid<=1; cnt increments.
  - When cnt==TOTAL-1, FSM returns to IDLE. done<=1 in the same edge, so done is coincident with the final out_valid.
- Per bank k, with s = cnt and o = k*PACK_PER_WORD:
  - In window when s>=o and (s-o)<seq_len.
  - In window: bank_en[k]=1, raddr_w[k]=base_w+(s-o), raddr_d[k]=base_d+(s-o).
  - Out of window: bank_en[k]=0, both addresses = DEPTH-1.
  - Arithmetic is evaluated at ADDR_W+2 bits. Never compute s-o when s<o; test first.
- Overflow: base+(s-o) > DEPTH-1 is handled per the Configuration section.
- hold=1 in RUN: cnt and addresses frozen, out_valid<=0, bank_en<=0. Resume on the next cycle with hold=0, with no step skipped.
- hold in IDLE has no effect.

## Timing
- Reset (rst=1 at an edge), including mid-run:
  - state=IDLE, cnt=0, busy=0, done=0, out_valid=0, bank_en=0.
  - All raddr_w/raddr_d lanes = DEPTH-1.
  - The aborted run never pulses done.
- Start sampled at edge E0. busy is high after E0.
- Step s outputs appear after edge E(s+1). One-cycle register latency from cnt.
- Without hold, the last step appears after E(TOTAL), together with done.
- busy falls after E(TOTAL). A new start is accepted at E(TOTAL+1) at the earliest.
- done and out_valid are single-cycle registered pulses.
- Addresses hold their last value while out_valid=0.

## Configuration
- ADDR_SEQ_WRAP_EN undefined: an in-window address whose sum exceeds DEPTH-1 saturates to DEPTH-1, and bank_en[k] stays 1.
- ADDR_SEQ_WRAP_EN defined: that sum wraps modulo DEPTH (circular buffer addressing), and bank_en[k] stays 1.
- Out-of-window lanes always use the DEPTH-1 guard, regardless of the macro.

## Test plan
- Basic skew:
  - Stimulus: NUM_BANKS=2, PACK=1, seq_len=4, base_w=0, base_d=10, start.
  - Response: 5 valid steps. Bank0 w=0,1,2,3,127 with en=1,1,1,1,0. Bank1 w=127,0,1,2,3 with en=0,1,1,1,1. Data lanes are offset by 10. done coincides with step 4.
- Hold:
  - Stimulus: same run, hold high for 2 cycles after step 1.
  - Response: out_valid low for 2 cycles with addresses frozen at step 1. Steps 2-4 follow unchanged. done appears 2 cycles later than in the basic run.
- Overflow:
  - Stimulus: base_w=126, seq_len=4.
  - Response without macro: bank0 addresses 126,127,127,127. With ADDR_SEQ_WRAP_EN: 126,127,0,1.
- Boundary start:
  - Stimulus: seq_len=0 start.
  - Response: done pulses after 1 cycle, busy stays 0, no out_valid.
  - Stimulus: start asserted during RUN.
  - Response: ignored, and the current run completes normally.
- Reset mid-run:
  - Stimulus: rst at step 2.
  - Response: next cycle all outputs are at reset values, with no done. A fresh start afterward yields the basic-skew sequence.
- Wide config:
  - Stimulus: NUM_BANKS=4, PACK=2, seq_len=3.
  - Response: TOTAL=9. Bank3 first enabled at step 6 with address base+0. Bank3's last enabled step is 8.

Source files
------------

// File: rtl/addr_seq_gen_if.sv
// addr_seq_gen_if: request/response bundle between a controller and the address sequencer.
// master drives the run request and stall; slave returns status and per-bank read addresses.
// Address lanes are packed bank-major: bank k occupies [k*ADDR_W +: ADDR_W].
interface addr_seq_gen_if #(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 10
);
  logic                          start;
  logic [ADDR_W-1:0]             seq_len;
  logic [ADDR_W-1:0]             base_w;
  logic [ADDR_W-1:0]             base_d;
  logic                          hold;
  logic                          busy;
  logic                          done;
  logic                          out_valid;
  logic [NUM_BANKS-1:0]          bank_en;
  logic [NUM_BANKS*ADDR_W-1:0]   raddr_w;
  logic [NUM_BANKS*ADDR_W-1:0]   raddr_d;

  // Controller side: issues runs and stalls, observes the address stream.
  modport master (
    output start, seq_len, base_w, base_d, hold,
    input  busy, done, out_valid, bank_en, raddr_w, raddr_d
  );

  // Sequencer side.
  modport slave (
    input  start, seq_len, base_w, base_d, hold,
    output busy, done, out_valid, bank_en, raddr_w, raddr_d
  );
endinterface

// File: rtl/addr_seq_gen.sv
// addr_seq_gen: skewed weight/data SRAM read-address sequencer for the systolic array.
// Latency: step s appears one cycle after the counter holds s; done coincides with the last step.
// Backpressure: hold freezes counter and addresses, drops out_valid/bank_en. Optional ADDR_SEQ_WRAP_EN wraps overflow.
module addr_seq_gen #(
  parameter int NUM_BANKS     = 2,
  parameter int ADDR_W        = 10,
  parameter int DEPTH         = 128,
  parameter int PACK_PER_WORD = 1
) (
  input  logic          clk,
  input  logic          rst,
  addr_seq_gen_if.slave bus
);

  // Internal arithmetic width: two spare bits so base+offset and the step count never overflow.
  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0]     GUARD_C = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] GUARD_A = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0]     SKEW_C  = CW'((NUM_BANKS - 1) * PACK_PER_WORD);
`ifdef ADDR_SEQ_WRAP_EN
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               last_step;
  logic [CW-1:0]               seq_len_q;
  logic [CW-1:0]               base_w_q;
  logic [CW-1:0]               base_d_q;

  logic                        busy_q;
  logic                        done_q;
  logic                        out_valid_q;
  logic [NUM_BANKS-1:0]        bank_en_q;
  logic [NUM_BANKS*ADDR_W-1:0] raddr_w_q;
  logic [NUM_BANKS*ADDR_W-1:0] raddr_d_q;

  // Per-bank view of the current counter value.
  logic [CW-1:0]               rel [NUM_BANKS];
  logic [NUM_BANKS-1:0]        win;
  logic [NUM_BANKS-1:0]        nxt_en;
  logic [NUM_BANKS*ADDR_W-1:0] nxt_w;
  logic [NUM_BANKS*ADDR_W-1:0] nxt_d;

  // Skew of bank k in serial steps.
  function automatic logic [CW-1:0] lane_off(input int k);
    return CW'(k * PACK_PER_WORD);
  endfunction

  // Fold an in-window sum that runs past the last SRAM row.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [CW-1:0] sum);
`ifdef ADDR_SEQ_WRAP_EN
    logic [CW-1:0] m;
    m = sum % DEPTH_C;
    return m[ADDR_W-1:0];
`else
    return (sum > GUARD_C) ? GUARD_A : sum[ADDR_W-1:0];
`endif
  endfunction

  // Window test per bank; the subtraction only happens once cnt has reached the lane offset.
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      rel[k] = '0;
      win[k] = 1'b0;
      if (cnt >= lane_off(k)) begin
        rel[k] = cnt - lane_off(k);
        win[k] = (rel[k] < seq_len_q);
      end
    end
  end

  // Next address/enable set for the step held in cnt; lanes outside the window park on the guard row.
  always_comb begin
    nxt_en = '0;
    nxt_w  = {NUM_BANKS{GUARD_A}};
    nxt_d  = {NUM_BANKS{GUARD_A}};
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (win[k]) begin
        nxt_en[k]                  = 1'b1;
        nxt_w[k*ADDR_W +: ADDR_W]  = map_addr(base_w_q + rel[k]);
        nxt_d[k*ADDR_W +: ADDR_W]  = map_addr(base_d_q + rel[k]);
      end
    end
  end

  // Control FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_step   <= '0;
      seq_len_q   <= '0;
      base_w_q    <= '0;
      base_d_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      bank_en_q   <= '0;
      raddr_w_q   <= {NUM_BANKS{GUARD_A}};
      raddr_d_q   <= {NUM_BANKS{GUARD_A}};
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.seq_len != '0) begin
              state     <= RUN;
              busy_q    <= 1'b1;
              cnt       <= '0;
              seq_len_q <= CW'(bus.seq_len);
              base_w_q  <= CW'(bus.base_w);
              base_d_q  <= CW'(bus.base_d);
              last_step <= CW'(bus.seq_len) + SKEW_C - CW'(1);
            end else begin
              // Empty run: acknowledge immediately, nothing is issued.
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.hold) begin
            // Stall: counter and addresses stay put, enables drop.
            bank_en_q <= '0;
          end else begin
            out_valid_q <= 1'b1;
            bank_en_q   <= nxt_en;
            raddr_w_q   <= nxt_w;
            raddr_d_q   <= nxt_d;
            if (cnt == last_step) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bank_en   = bank_en_q;
  assign bus.raddr_w   = raddr_w_q;
  assign bus.raddr_d   = raddr_d_q;

endmodule
